// File: rtl/bf_pkg.sv
// Shared definitions for the Brainfuck execution core: opcodes, FSM states, error codes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bf_pkg;

    // ASCII opcodes
    localparam logic [7:0] OP_INC   = 8'h2B; // +
    localparam logic [7:0] OP_DEC   = 8'h2D; // -
    localparam logic [7:0] OP_RIGHT = 8'h3E; // >
    localparam logic [7:0] OP_LEFT  = 8'h3C; // <
    localparam logic [7:0] OP_OUT   = 8'h2E; // .
    localparam logic [7:0] OP_IN    = 8'h2C; // ,
    localparam logic [7:0] OP_LBR   = 8'h5B; // [
    localparam logic [7:0] OP_RBR   = 8'h5D; // ]

    // Error codes reported on err_code
    localparam logic [1:0] ERR_NONE            = 2'd0;
    localparam logic [1:0] ERR_UNMATCHED_CLOSE = 2'd1;
    localparam logic [1:0] ERR_UNMATCHED_OPEN  = 2'd2;
    localparam logic [1:0] ERR_STACK_OVF       = 2'd3;

    typedef enum logic [4:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ZERO,
        ST_PRE_F,      // present scan address to program RAM
        ST_PRE_D,      // classify scanned byte
        ST_PRE_POP,    // stack data valid: write jump[p] = i
        ST_PRE_POP2,   // write jump[i] = p
        ST_FETCH,
        ST_DECODE,
        ST_MV_WR,      // write back cached cell, move dptr
        ST_MV_RD,      // tape read of new cell in flight
        ST_MV_LAT,     // capture new cell
        ST_IN_WAIT,
        ST_OUT_WAIT,
        ST_STEP_WAIT,
        ST_DONE,
        ST_ERROR
    } state_t;

endpackage

// File: rtl/bf_ram.sv
// Generic synchronous RAM: one read/write port, optional second read-only port.
// Latency: registered reads, 1 cycle on both ports; reads during a write return old data.
// Backpressure: none, accepts an access every cycle.
// Ports: clk_i/rst_i (rst clears read registers only), a_* read/write port, b_* read-only port.
module bf_ram #(
    parameter int AW     = 8,
    parameter int DW     = 8,
    parameter bit RD2_EN = 1'b0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [AW-1:0] a_addr_i,
    input  logic          a_we_i,
    input  logic [DW-1:0] a_wdata_i,
    output logic [DW-1:0] a_rdata_o,
    input  logic [AW-1:0] b_addr_i,
    output logic [DW-1:0] b_rdata_o
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [0:DEPTH-1];
    logic [DW-1:0] a_rdata_q;

    always_ff @(posedge clk_i) begin
        if (a_we_i) begin
            mem_q[a_addr_i] <= a_wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_rdata_q <= '0;
        end else begin
            a_rdata_q <= mem_q[a_addr_i];
        end
    end

    assign a_rdata_o = a_rdata_q;

    generate
        if (RD2_EN) begin : g_rd2
            logic [DW-1:0] b_rdata_q;
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    b_rdata_q <= '0;
                end else begin
                    b_rdata_q <= mem_q[b_addr_i];
                end
            end
            assign b_rdata_o = b_rdata_q;
        end else begin : g_no_rd2
            logic unused_b_addr;
            assign unused_b_addr = ^b_addr_i;
            assign b_rdata_o     = '0;
        end
    endgenerate

endmodule

// File: rtl/bf_exec_core.sv
// Brainfuck execution core: streaming program load, bracket pre-match, cached-cell execution.
// Latency: +,-,[,],no-op 2 cycles; >,< 5 cycles; , and . 2 cycles plus handshake wait.
// Backpressure: load_ready/in_ready/out_valid are held until the matching handshake completes.
// Ports: load_* program stream, start_req/step_req control, in_*/out_* byte streams,
//        view_addr/view_cell second tape read port, loaded/busy/done/error/err_code status.
// Optional: define BF_STEP_EN to pause in STEP_WAIT after every '.' until step_req.
module bf_exec_core
    import bf_pkg::*;
#(
    parameter int PROG_AW  = 14,
    parameter int DATA_AW  = 12,
    parameter int CELL_W   = 8,
    parameter int STACK_AW = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_req,
    input  logic               load_valid,
    output logic               load_ready,
    input  logic [7:0]         load_data,
    input  logic               load_last,
    input  logic               start_req,
    input  logic               step_req,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CELL_W-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CELL_W-1:0]  out_data,
    input  logic [DATA_AW-1:0] view_addr,
    output logic [CELL_W-1:0]  view_cell,
    output logic               loaded,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [1:0]         err_code
);

    state_t              state_q;
    // One extra bit: a full program has prog_len == 2^PROG_AW.
    logic [PROG_AW:0]    iptr_q;
    logic [PROG_AW:0]    prog_len_q;
    logic [DATA_AW-1:0]  dptr_q;
    logic [STACK_AW:0]   sp_q;
    logic [CELL_W-1:0]   cell_q;
    logic [PROG_AW-1:0]  pair_q;
    logic                mv_left_q;
    logic                load_ready_q;
    logic                in_ready_q;
    logic                out_valid_q;
    logic [CELL_W-1:0]   out_data_q;
    logic                loaded_q;
    logic                busy_q;
    logic                done_q;
    logic                error_q;
    logic [1:0]          err_code_q;

    // RAM control
    logic                prog_we;
    logic [7:0]          prog_rdata;
    logic                jump_we;
    logic [PROG_AW-1:0]  jump_addr;
    logic [PROG_AW-1:0]  jump_wdata;
    logic [PROG_AW-1:0]  jump_rdata;
    logic                stack_we;
    logic [STACK_AW-1:0] stack_addr;
    logic [PROG_AW-1:0]  stack_rdata;
    logic                tape_we;
    logic [CELL_W-1:0]   tape_wdata;
    logic [CELL_W-1:0]   tape_rdata;
    logic                at_end;
    logic [PROG_AW:0]    jump_next;

    logic [7:0]          unused_prog_b;
    logic [PROG_AW-1:0]  unused_jump_b;
    logic [PROG_AW-1:0]  unused_stack_b;

    assign at_end    = (iptr_q == prog_len_q);
    assign jump_next = {1'b0, jump_rdata} + 1'b1;

    always_comb begin
        prog_we    = (state_q == ST_LOAD) && load_valid;

        jump_we    = 1'b0;
        jump_addr  = iptr_q[PROG_AW-1:0];
        jump_wdata = pair_q;
        if (state_q == ST_PRE_POP) begin
            jump_we    = 1'b1;
            jump_addr  = stack_rdata;
            jump_wdata = iptr_q[PROG_AW-1:0];
        end else if (state_q == ST_PRE_POP2) begin
            jump_we    = 1'b1;
        end

        // Push writes at sp; otherwise keep the top-of-stack read in flight so a
        // ']' decoded in PRE_D has its partner address ready in PRE_POP.
        stack_we   = (state_q == ST_PRE_D) && (prog_rdata == OP_LBR) && !sp_q[STACK_AW];
        stack_addr = stack_we ? sp_q[STACK_AW-1:0] : sp_q[STACK_AW-1:0] - 1'b1;

        tape_we    = (state_q == ST_ZERO) || (state_q == ST_MV_WR) ||
                     ((state_q == ST_FETCH) && at_end);
        tape_wdata = (state_q == ST_ZERO) ? '0 : cell_q;
    end

    bf_ram #(.AW(PROG_AW), .DW(8), .RD2_EN(1'b0)) u_prog_ram (
        .clk_i     (clk),
        .rst_i     (reset),
        .a_addr_i  (iptr_q[PROG_AW-1:0]),
        .a_we_i    (prog_we),
        .a_wdata_i (load_data),
        .a_rdata_o (prog_rdata),
        .b_addr_i  ('0),
        .b_rdata_o (unused_prog_b)
    );

    bf_ram #(.AW(PROG_AW), .DW(PROG_AW), .RD2_EN(1'b0)) u_jump_ram (
        .clk_i     (clk),
        .rst_i     (reset),
        .a_addr_i  (jump_addr),
        .a_we_i    (jump_we),
        .a_wdata_i (jump_wdata),
        .a_rdata_o (jump_rdata),
        .b_addr_i  ('0),
        .b_rdata_o (unused_jump_b)
    );

    bf_ram #(.AW(STACK_AW), .DW(PROG_AW), .RD2_EN(1'b0)) u_stack_ram (
        .clk_i     (clk),
        .rst_i     (reset),
        .a_addr_i  (stack_addr),
        .a_we_i    (stack_we),
        .a_wdata_i (iptr_q[PROG_AW-1:0]),
        .a_rdata_o (stack_rdata),
        .b_addr_i  ('0),
        .b_rdata_o (unused_stack_b)
    );

    bf_ram #(.AW(DATA_AW), .DW(CELL_W), .RD2_EN(1'b1)) u_tape_ram (
        .clk_i     (clk),
        .rst_i     (reset),
        .a_addr_i  (dptr_q),
        .a_we_i    (tape_we),
        .a_wdata_i (tape_wdata),
        .a_rdata_o (tape_rdata),
        .b_addr_i  (view_addr),
        .b_rdata_o (view_cell)
    );

`ifndef BF_STEP_EN
    logic unused_step;
    assign unused_step = step_req;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            iptr_q       <= '0;
            prog_len_q   <= '0;
            dptr_q       <= '0;
            sp_q         <= '0;
            cell_q       <= '0;
            pair_q       <= '0;
            mv_left_q    <= 1'b0;
            load_ready_q <= 1'b0;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            loaded_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            err_code_q   <= ERR_NONE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (load_req) begin
                        state_q      <= ST_LOAD;
                        iptr_q       <= '0;
                        load_ready_q <= 1'b1;
                        loaded_q     <= 1'b0;
                        done_q       <= 1'b0;
                        error_q      <= 1'b0;
                        err_code_q   <= ERR_NONE;
                    end else if (start_req && loaded_q) begin
                        state_q    <= ST_ZERO;
                        iptr_q     <= '0;
                        dptr_q     <= '0;
                        sp_q       <= '0;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        error_q    <= 1'b0;
                        err_code_q <= ERR_NONE;
                    end
                end

                ST_LOAD: begin
                    if (load_valid) begin
                        iptr_q <= iptr_q + 1'b1;
                        // Last byte, or the final slot: anything further is truncated.
                        if (load_last || (&iptr_q[PROG_AW-1:0])) begin
                            prog_len_q   <= iptr_q + 1'b1;
                            loaded_q     <= 1'b1;
                            load_ready_q <= 1'b0;
                            state_q      <= ST_IDLE;
                        end
                    end
                end

                ST_ZERO: begin
                    // dptr wraps back to 0 after the last cell, ready for EXEC.
                    dptr_q <= dptr_q + 1'b1;
                    if (&dptr_q) begin
                        state_q <= ST_PRE_F;
                    end
                end

                ST_PRE_F: begin
                    if (at_end) begin
                        if (sp_q != '0) begin
                            state_q    <= ST_ERROR;
                            error_q    <= 1'b1;
                            err_code_q <= ERR_UNMATCHED_OPEN;
                            busy_q     <= 1'b0;
                        end else begin
                            state_q <= ST_FETCH;
                            iptr_q  <= '0;
                            cell_q  <= '0;
                        end
                    end else begin
                        state_q <= ST_PRE_D;
                    end
                end

                ST_PRE_D: begin
                    if (prog_rdata == OP_LBR) begin
                        if (sp_q[STACK_AW]) begin
                            state_q    <= ST_ERROR;
                            error_q    <= 1'b1;
                            err_code_q <= ERR_STACK_OVF;
                            busy_q     <= 1'b0;
                        end else begin
                            sp_q    <= sp_q + 1'b1;
                            iptr_q  <= iptr_q + 1'b1;
                            state_q <= ST_PRE_F;
                        end
                    end else if (prog_rdata == OP_RBR) begin
                        if (sp_q == '0) begin
                            state_q    <= ST_ERROR;
                            error_q    <= 1'b1;
                            err_code_q <= ERR_UNMATCHED_CLOSE;
                            busy_q     <= 1'b0;
                        end else begin
                            state_q <= ST_PRE_POP;
                        end
                    end else begin
                        iptr_q  <= iptr_q + 1'b1;
                        state_q <= ST_PRE_F;
                    end
                end

                ST_PRE_POP: begin
                    pair_q  <= stack_rdata;
                    state_q <= ST_PRE_POP2;
                end

                ST_PRE_POP2: begin
                    sp_q    <= sp_q - 1'b1;
                    iptr_q  <= iptr_q + 1'b1;
                    state_q <= ST_PRE_F;
                end

                ST_FETCH: begin
                    // At the end the cached cell is written back this same cycle.
                    if (at_end) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= ST_DECODE;
                    end
                end

                ST_DECODE: begin
                    iptr_q  <= iptr_q + 1'b1;
                    state_q <= ST_FETCH;
                    case (prog_rdata)
                        OP_INC: cell_q <= cell_q + 1'b1;
                        OP_DEC: cell_q <= cell_q - 1'b1;
                        OP_RIGHT, OP_LEFT: begin
                            mv_left_q <= (prog_rdata == OP_LEFT);
                            state_q   <= ST_MV_WR;
                        end
                        OP_LBR: begin
                            if (cell_q == '0) iptr_q <= jump_next;
                        end
                        OP_RBR: begin
                            if (cell_q != '0) iptr_q <= jump_next;
                        end
                        OP_IN: begin
                            in_ready_q <= 1'b1;
                            state_q    <= ST_IN_WAIT;
                        end
                        OP_OUT: begin
                            out_valid_q <= 1'b1;
                            out_data_q  <= cell_q;
                            state_q     <= ST_OUT_WAIT;
                        end
                        default: ;
                    endcase
                end

                ST_MV_WR: begin
                    dptr_q  <= mv_left_q ? dptr_q - 1'b1 : dptr_q + 1'b1;
                    state_q <= ST_MV_RD;
                end

                ST_MV_RD: begin
                    state_q <= ST_MV_LAT;
                end

                ST_MV_LAT: begin
                    cell_q  <= tape_rdata;
                    state_q <= ST_FETCH;
                end

                ST_IN_WAIT: begin
                    if (in_valid) begin
                        cell_q     <= in_data;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_FETCH;
                    end
                end

                ST_OUT_WAIT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
`ifdef BF_STEP_EN
                        state_q     <= ST_STEP_WAIT;
`else
                        state_q     <= ST_FETCH;
`endif
                    end
                end

`ifdef BF_STEP_EN
                ST_STEP_WAIT: begin
                    if (step_req) begin
                        state_q <= ST_FETCH;
                    end
                end
`endif

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign load_ready = load_ready_q;
    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign loaded     = loaded_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign err_code   = err_code_q;

endmodule
